code_mem_ctrl: RTL and testbench
================================

CODE_MEM_CTRL -- requirements
Module: code_mem_ctrl

Interface
REQ-001 Parameter: PF_DEPTH, default 2, prefetch queue depth in bytes.
REQ-002 Parameter: ROM_LAST, default 16'h0410, highest implemented code address.
REQ-003 Parameter: FILL_BYTE, default 8'h00 (NOP), byte returned for unimplemented addresses.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 flush  in  1  branch taken; discard the prefetch queue and redirect fetch.
REQ-007 flush_addr  in  16  new fetch address, valid with flush.
REQ-008 if_ready  in  1  core consumes if_byte this cycle.
REQ-009 if_vld  out  1  if_byte/if_pc valid.
REQ-010 if_byte  out  8  head-of-queue opcode/operand byte.
REQ-011 if_pc  out  16  code address of if_byte.
REQ-012 movc_req  in  1  MOVC data-read request, held until movc_done.
REQ-013 movc_addr  in  16  MOVC address, stable while movc_req is high.
REQ-014 movc_byte  out  8  MOVC result, held until the next MOVC completes.
REQ-015 movc_done  out  1  one-cycle completion pulse.
REQ-016 rom_en  out  1  ROM access enable.
REQ-017 rom_addr  out  16  ROM address.
REQ-018 rom_byte  in  8  ROM data, combinational from rom_en/rom_addr in the same cycle.

Function
REQ-019 One ROM access per cycle at most; rom_en is high only in a cycle where an access is granted, else rom_addr = 0.
REQ-020 FSM states: FETCH, MOVC_ACC, MOVC_DONE; FETCH->MOVC_ACC when movc_req=1 and not in MOVC_DONE; MOVC_ACC->MOVC_DONE unconditionally; MOVC_DONE->FETCH unconditionally.
REQ-021 MOVC_ACC: rom_addr = movc_addr, rom_byte registered into movc_byte; no fetch that cycle.
REQ-022 MOVC_DONE: movc_done=1 for exactly this cycle; movc_req ignored this cycle; fetch permitted.
REQ-023 Fetch is issued in FETCH/MOVC_DONE when count < PF_DEPTH, or count == PF_DEPTH and if_vld & if_ready (simultaneous push/pop).
REQ-024 A fetch pushes {fpc, rom_byte} at the cycle's end; fpc increments by 1, wrapping 16'hFFFF->16'h0000.
REQ-025 Fetch address > ROM_LAST: rom_en stays 0, FILL_BYTE pushed, fpc still increments.
REQ-026 Pop when if_vld & if_ready; if_vld = (count != 0); outputs show the queue head, first-in-first-out.
REQ-027 Fetch latency: byte is visible on if_byte the cycle after its ROM access.
REQ-028 flush: at the cycle's end the queue is emptied and fpc = flush_addr; any fetch or pop in the flush cycle is discarded; if_vld is 0 in the next cycle.
REQ-029 flush concurrent with MOVC_ACC: the MOVC completes normally; the flush still applies to queue and fpc.
REQ-030 movc_req with movc_addr > ROM_LAST: movc_byte = FILL_BYTE, rom_en = 0, same timing.

Reset
REQ-031 reset asserts asynchronously: state=FETCH, fpc=16'h0000, queue empty, if_vld=0, if_byte=0, if_pc=0, movc_byte=0, movc_done=0, rom_en=0, rom_addr=0.
REQ-032 First fetch (address 0) in the first cycle after reset deassertion; if_vld high the following cycle.
REQ-033 Reset mid-MOVC abandons it; no movc_done is produced.

Structure
REQ-034 Shared package code_mem_pkg holds ADDR_W=16, DATA_W=8, ROM_LAST, FILL_BYTE and the FSM state type.
REQ-035 Prefetch queue is sub-module fetch_fifo (PF_DEPTH entries of {addr,byte}, push/pop/clear, count).

Verification
REQ-036 Reset release with ROM[0]=8'h74, ROM[1]=8'h02, if_ready=1 -> if_byte 8'h74 @pc 0, then 8'h02 @pc 1 on consecutive cycles.
REQ-037 if_ready=0 for 5 cycles -> exactly 2 ROM accesses, count=2; if_ready=1 -> a push and a pop occur in the same cycle, with no gap in if_vld.
REQ-038 flush, flush_addr=16'h000B, ROM[11]=8'h24 -> if_vld=0 next cycle; then if_byte 8'h24 @pc 000B.
REQ-039 movc_req, movc_addr=16'h000D (ROM=8'h32) during steady fetch -> one fetch-free cycle, movc_byte=8'h32, movc_done pulse 1 cycle, fetch resumes in order.
REQ-040 flush_addr=16'h040F -> bytes at 040F and 0410 come from the ROM; 0411 returns 8'h00 with rom_en=0; a fetch from FFFF wraps to 0000.
REQ-041 reset asserted during MOVC_ACC -> all outputs reach reset values immediately and no movc_done is produced.

Source files
------------

// File: rtl/code_mem_pkg.sv
// Shared definitions for the code-memory controller: bus widths, ROM map limits,
// controller state type and the prefetch queue entry layout.
package code_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ROM_LAST  = 16'h0410;
  localparam logic [DATA_W-1:0] FILL_BYTE = 8'h00;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    MOVC_ACC  = 2'd1,
    MOVC_DONE = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pf_entry_t;

  // Bytes beyond the implemented ROM read back as the fill opcode.
  function automatic logic [DATA_W-1:0] rom_or_fill(
    input logic              hit,
    input logic [DATA_W-1:0] rom_data,
    input logic [DATA_W-1:0] fill_data
  );
    return hit ? rom_data : fill_data;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch queue of {addr, byte} entries with push, pop, clear and an
// occupancy count; the head entry is presented combinationally.
module fetch_fifo
  import code_mem_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  pf_entry_t        push_entry,
  output logic             head_vld,
  output pf_entry_t        head_entry,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  pf_entry_t [DEPTH-1:0] slots;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Clear wins over push and pop so a redirect never leaks a stale byte.
  assign do_push = push & ~clear;
  assign do_pop  = pop & ~clear & (count_reg != '0);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    pf_entry_t entry_reg;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        entry_reg <= '0;
      end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
        entry_reg <= push_entry;
      end
    end

    assign slots[gi] = entry_reg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head_vld   = (count_reg != '0);
  assign head_entry = head_vld ? slots[rd_ptr_reg] : '0;
  assign count      = count_reg;

endmodule

// File: rtl/code_mem_ctrl.sv
// Code-memory controller: arbitrates a single-ported ROM between the instruction
// prefetcher and MOVC data reads, with branch flush of the prefetch queue.
module code_mem_ctrl
  import code_mem_pkg::*;
#(
  parameter int                PF_DEPTH  = 2,
  parameter logic [ADDR_W-1:0] ROM_LAST  = code_mem_pkg::ROM_LAST,
  parameter logic [DATA_W-1:0] FILL_BYTE = code_mem_pkg::FILL_BYTE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  input  logic              if_ready,
  output logic              if_vld,
  output logic [DATA_W-1:0] if_byte,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              movc_req,
  input  logic [ADDR_W-1:0] movc_addr,
  output logic [DATA_W-1:0] movc_byte,
  output logic              movc_done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_byte
);

  localparam int               CNT_W   = $clog2(PF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PF_DEPTH);

  ctrl_state_e       state_reg;
  ctrl_state_e       state_next;
  logic [ADDR_W-1:0] fpc_reg;
  logic [ADDR_W-1:0] fpc_next;
  logic [DATA_W-1:0] movc_byte_reg;
  logic [CNT_W-1:0]  pf_count;
  pf_entry_t         push_entry;
  pf_entry_t         head_entry;
  logic              head_vld;
  logic              pop;
  logic              fetch_go;
  logic              fetch_hit;
  logic              movc_hit;
  logic              movc_acc;

  assign pop       = head_vld & if_ready;
  assign fetch_hit = (fpc_reg <= ROM_LAST);
  assign movc_hit  = (movc_addr <= ROM_LAST);
  assign movc_acc  = (state_reg == MOVC_ACC);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= FETCH;
      fpc_reg       <= '0;
      movc_byte_reg <= '0;
    end else begin
      state_reg <= state_next;
      fpc_reg   <= fpc_next;
      if (movc_acc) begin
        movc_byte_reg <= rom_or_fill(movc_hit, rom_byte, FILL_BYTE);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    fetch_go   = 1'b0;
    rom_en     = 1'b0;
    rom_addr   = '0;

    unique case (state_reg)
      FETCH:     if (movc_req) state_next = MOVC_ACC;
      MOVC_ACC:  state_next = MOVC_DONE;
      MOVC_DONE: state_next = FETCH;
      default:   state_next = FETCH;
    endcase

    // A full queue may still accept a byte when the head leaves in the same cycle.
    if (!reset && !flush && !movc_acc) begin
      fetch_go = (pf_count < DEPTH_C) || ((pf_count == DEPTH_C) && pop);
    end

    if (!reset) begin
      if (movc_acc) begin
        if (movc_hit) begin
          rom_en   = 1'b1;
          rom_addr = movc_addr;
        end
      end else if (fetch_go && fetch_hit) begin
        rom_en   = 1'b1;
        rom_addr = fpc_reg;
      end
    end
  end

  always_comb begin
    fpc_next = fpc_reg;
    if (flush) begin
      fpc_next = flush_addr;
    end else if (fetch_go) begin
      fpc_next = fpc_reg + ADDR_W'(1);
    end
  end

  assign push_entry = '{addr: fpc_reg, data: rom_or_fill(fetch_hit, rom_byte, FILL_BYTE)};

  fetch_fifo #(
    .DEPTH (PF_DEPTH)
  ) u_fetch_fifo (
    .clock      (clock),
    .reset      (reset),
    .clear      (flush),
    .push       (fetch_go),
    .pop        (pop),
    .push_entry (push_entry),
    .head_vld   (head_vld),
    .head_entry (head_entry),
    .count      (pf_count)
  );

  assign if_vld    = head_vld;
  assign if_byte   = head_entry.data;
  assign if_pc     = head_entry.addr;
  assign movc_byte = movc_byte_reg;
  assign movc_done = (state_reg == MOVC_DONE);

endmodule

// File: tb/tb_code_mem_ctrl.sv
// Bench for code_mem_ctrl: ROM model, scoreboard of the expected fetch stream,
// and directed checks on reset, back-pressure, flush, MOVC and address limits.
module tb_code_mem_ctrl;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [15:0] flush_addr;
  logic        if_ready;
  logic        if_vld;
  logic [7:0]  if_byte;
  logic [15:0] if_pc;
  logic        movc_req;
  logic [15:0] movc_addr;
  logic [7:0]  movc_byte;
  logic        movc_done;
  logic        rom_en;
  logic [15:0] rom_addr;
  logic [7:0]  rom_byte;

  logic [7:0]  rom_mem [65536];

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  b;
  } sb_t;
  sb_t expq[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int rom_acc_cnt  = 0;
  int done_cnt     = 0;

  code_mem_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .flush_addr (flush_addr),
    .if_ready   (if_ready),
    .if_vld     (if_vld),
    .if_byte    (if_byte),
    .if_pc      (if_pc),
    .movc_req   (movc_req),
    .movc_addr  (movc_addr),
    .movc_byte  (movc_byte),
    .movc_done  (movc_done),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_byte   (rom_byte)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Undriven ROM reads return a marker byte so a missing fill substitution shows up.
  assign rom_byte = rom_en ? rom_mem[rom_addr] : 8'hEE;

  function automatic logic [7:0] exp_byte(input logic [15:0] a);
    return (a <= 16'h0410) ? rom_mem[a] : 8'h00;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_load(input logic [15:0] start);
    logic [15:0] a;
    expq.delete();
    a = start;
    for (int i = 0; i < 32; i++) begin
      expq.push_back('{a, exp_byte(a)});
      a = a + 16'd1;
    end
  endtask

  // Mid-cycle observation; every consumed byte is compared against the scoreboard.
  task automatic sample();
    sb_t e;
    @(negedge clock);
    if (rom_en) rom_acc_cnt++;
    if (movc_done) done_cnt++;
    if (if_vld && if_ready && !flush) begin
      if (expq.size() == 0) begin
        check_eq("sb_underflow", 32'(expq.size()), 32'd1);
      end else begin
        e = expq.pop_front();
        check_eq("sb_pc", 32'(if_pc), 32'(e.pc));
        check_eq("sb_byte", 32'(if_byte), 32'(e.b));
        $display("[TB] consume pc=%04h byte=%02h", if_pc, if_byte);
      end
    end
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic do_flush(input logic [15:0] a);
    flush      = 1'b1;
    flush_addr = a;
    sample();
    advance();
    flush = 1'b0;
    sb_load(a);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      rom_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
    end
    rom_mem[0]  = 8'h74;
    rom_mem[1]  = 8'h02;
    rom_mem[11] = 8'h24;
    rom_mem[13] = 8'h32;

    reset      = 1'b1;
    flush      = 1'b0;
    flush_addr = '0;
    if_ready   = 1'b1;
    movc_req   = 1'b0;
    movc_addr  = '0;

    // Reset state
    advance();
    advance();
    sample();
    check_eq("rst_if_vld", if_vld, 0);
    check_eq("rst_if_byte", if_byte, 0);
    check_eq("rst_if_pc", if_pc, 0);
    check_eq("rst_movc_byte", movc_byte, 0);
    check_eq("rst_movc_done", movc_done, 0);
    check_eq("rst_rom_en", rom_en, 0);
    check_eq("rst_rom_addr", rom_addr, 0);
    advance();

    // First fetch right after release, byte visible one cycle later
    reset = 1'b0;
    sb_load(16'h0000);
    sample();
    check_eq("first_rom_en", rom_en, 1);
    check_eq("first_rom_addr", rom_addr, 16'h0000);
    check_eq("first_if_vld", if_vld, 0);
    advance();
    sample();
    check_eq("second_if_vld", if_vld, 1);
    advance();
    run(4);

    // Back-pressure: from an empty queue only PF_DEPTH accesses happen
    if_ready = 1'b0;
    do_flush(16'h0020);
    rom_acc_cnt = 0;
    run(5);
    check_eq("bp_rom_accesses", 32'(rom_acc_cnt), 32'd2);
    check_eq("bp_if_vld", if_vld, 1);
    if_ready = 1'b1;
    sample();
    check_eq("bp_push_pop_rom_en", rom_en, 1);
    check_eq("bp_push_pop_addr", rom_addr, 16'h0022);
    advance();
    for (int i = 0; i < 4; i++) begin
      sample();
      check_eq("bp_no_gap", if_vld, 1);
      advance();
    end

    // Flush redirect
    do_flush(16'h000B);
    sample();
    check_eq("flush_if_vld", if_vld, 0);
    check_eq("flush_rom_addr", rom_addr, 16'h000B);
    advance();
    run(4);

    // MOVC during steady fetch
    done_cnt  = 0;
    movc_req  = 1'b1;
    movc_addr = 16'h000D;
    sample();
    check_eq("movc_no_done_early", movc_done, 0);
    advance();
    sample();
    check_eq("movc_acc_rom_en", rom_en, 1);
    check_eq("movc_acc_rom_addr", rom_addr, 16'h000D);
    advance();
    sample();
    check_eq("movc_done_pulse", movc_done, 1);
    check_eq("movc_byte", movc_byte, 8'h32);
    movc_req = 1'b0;
    advance();
    sample();
    check_eq("movc_done_drop", movc_done, 0);
    advance();
    run(4);
    check_eq("movc_done_count", 32'(done_cnt), 32'd1);

    // MOVC to an unimplemented address returns the fill byte without a ROM access
    movc_req  = 1'b1;
    movc_addr = 16'h0500;
    run(1);
    sample();
    check_eq("movc_oor_rom_en", rom_en, 0);
    advance();
    sample();
    check_eq("movc_oor_byte", movc_byte, 8'h00);
    movc_req = 1'b0;
    advance();
    run(2);

    // Flush while the MOVC access is in flight
    movc_req  = 1'b1;
    movc_addr = 16'h0007;
    run(1);
    flush      = 1'b1;
    flush_addr = 16'h0030;
    sample();
    check_eq("movc_flush_rom_addr", rom_addr, 16'h0007);
    advance();
    flush = 1'b0;
    sb_load(16'h0030);
    sample();
    check_eq("movc_flush_done", movc_done, 1);
    check_eq("movc_flush_byte", movc_byte, 32'(rom_mem[7]));
    check_eq("movc_flush_if_vld", if_vld, 0);
    movc_req = 1'b0;
    advance();
    run(4);

    // ROM end boundary
    do_flush(16'h040F);
    sample();
    check_eq("end_rom_addr_040f", rom_addr, 16'h040F);
    advance();
    sample();
    check_eq("end_rom_en_0410", rom_en, 1);
    check_eq("end_rom_addr_0410", rom_addr, 16'h0410);
    advance();
    sample();
    check_eq("end_rom_en_0411", rom_en, 0);
    check_eq("end_rom_addr_0411", rom_addr, 0);
    advance();
    run(3);

    // Fetch counter wrap
    do_flush(16'hFFFE);
    run(6);

    // Reset in the middle of a MOVC access
    movc_req  = 1'b1;
    movc_addr = 16'h000D;
    run(1);
    #1;
    reset    = 1'b1;
    movc_req = 1'b0;
    #1;
    check_eq("mid_rst_if_vld", if_vld, 0);
    check_eq("mid_rst_if_byte", if_byte, 0);
    check_eq("mid_rst_if_pc", if_pc, 0);
    check_eq("mid_rst_movc_byte", movc_byte, 0);
    check_eq("mid_rst_rom_en", rom_en, 0);
    check_eq("mid_rst_rom_addr", rom_addr, 0);
    done_cnt = 0;
    run(2);
    reset = 1'b0;
    sb_load(16'h0000);
    run(5);
    check_eq("mid_rst_no_done", 32'(done_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
